mem_wb_loadext: RTL

//  MEM/WB pipeline register plus load-data extension, directly downstream of the data memory.

---
 rtl/mem_wb_loadext_pkg.sv | 48 ++++
 rtl/mem_wb_loadext_load_ext.sv | 39 +++
 rtl/mem_wb_loadext.sv | 83 ++++++++
 3 files changed

// File: rtl/mem_wb_loadext_pkg.sv
// Shared definitions for the MEM/WB stage: load-op and write-back-select codes,
// the PC reset value, the pipeline-register record and the extension helpers.
package mem_wb_loadext_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_LW   = 3'd1;
    localparam logic [2:0] LOAD_LB   = 3'd2;
    localparam logic [2:0] LOAD_LBU  = 3'd3;
    localparam logic [2:0] LOAD_LH   = 3'd4;
    localparam logic [2:0] LOAD_LHU  = 3'd5;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [31:0] LINK_OFFSET = 32'd8;

    // Everything the WB stage remembers about one instruction.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [1:0]  off;
        logic [2:0]  load_op;
        logic [1:0]  wb_sel;
        logic [4:0]  rd;
        logic        regwrite;
    } wb_reg_t;

    function automatic wb_reg_t wb_bubble(input logic [31:0] pc_reset);
        wb_reg_t r;
        r          = '0;
        r.pc       = pc_reset;
        return r;
    endfunction

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sign);
        return {{24{sign & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sign);
        return {{16{sign & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_loadext_load_ext.sv
// Combinational load-data extension: picks the addressed byte/halfword of the
// memory word and sign- or zero-extends it to 32 bits.
module load_ext
    import mem_wb_loadext_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  load_op,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    // Halfword loads are aligned, so only off[1] selects; off[0] is always 0 here.
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: default assignment first so every path drives ext and no latch is inferred.
        ext = rdata;
        case (load_op)
            LOAD_LB:  ext = ext_byte(byte_sel, 1'b1);
            LOAD_LBU: ext = ext_byte(byte_sel, 1'b0);
            LOAD_LH:  ext = ext_half(half_sel, 1'b1);
            LOAD_LHU: ext = ext_half(half_sel, 1'b0);
            default:  ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_loadext.sv
// MEM/WB pipeline register with load-data extension feeding the GRF write port.
// Optional: define WB_TRACE_EN to print one line per retired register write.
module mem_wb_loadext
    import mem_wb_loadext_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_dm_rdata,
    input  logic [2:0]  m_load_op,
    input  logic [1:0]  m_wb_sel,
    input  logic [4:0]  m_rd,
    input  logic        m_regwrite,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc
);

    wb_reg_t     wb_q;
    wb_reg_t     wb_d;
    logic [31:0] ext;

    always_comb begin
        wb_d.valid    = 1'b1;
        wb_d.pc       = m_pc;
        wb_d.alu      = m_alu;
        wb_d.rdata    = m_dm_rdata;
        wb_d.off      = m_alu[1:0];
        wb_d.load_op  = m_load_op;
        wb_d.wb_sel   = m_wb_sel;
        wb_d.rd       = m_rd;
        wb_d.regwrite = m_regwrite;
    end

    // Flush outranks stall so a frozen instruction can still be killed.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state to avoid simulation races.
        if (reset || flush) begin
            wb_q <= wb_bubble(PC_RESET);
        end else if (!stall) begin
            wb_q <= wb_d;
        end
    end

    load_ext u_load_ext (
        .rdata   (wb_q.rdata),
        .off     (wb_q.off),
        .load_op (wb_q.load_op),
        .ext     (ext)
    );

    always_comb begin
        wb_data = 32'h0;
        case (wb_q.wb_sel)
            WB_SEL_ALU:  wb_data = wb_q.alu;
            WB_SEL_MEM:  wb_data = ext;
            WB_SEL_LINK: wb_data = wb_q.pc + LINK_OFFSET;
            default:     wb_data = 32'h0;
        endcase
    end

    // $0 is hard-wired, so a write to it is never issued.
    assign wb_we   = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0);
    assign wb_addr = wb_q.rd;
    assign wb_pc   = wb_q.pc;

`ifdef WB_TRACE_EN
    // A stalled stage holds the same write; print it only once.
    always_ff @(posedge clk) begin
        if (!reset && !stall && wb_we) begin
            $display("%d@%h: $%d <= %h", $time, wb_pc, wb_addr, wb_data);
        end
    end
`else
`endif

endmodule
